// File: rtl/t_ff_bank_sequencer.sv
// t_ff_bank_sequencer: FSM driving a WIDTH-bit bank of T flip-flops as an
// up/down counter that stops on a programmed target.
// Optional feature macro: TFF_SEQ_STEP_CNT_EN (adds step_cnt output).

// Single T flip-flop with synchronous clear; one instance per bank bit.
module t_ff_bank_sequencer_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic t,
  output logic q
);
  // toggle on t, clear wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= 1'b0;
    else if (clr) q <= 1'b0;
    else          q <= q ^ t;
  end
endmodule

module t_ff_bank_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             up_down,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] t_en,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
`ifdef TFF_SEQ_STEP_CNT_EN
  ,output logic [WIDTH:0]  step_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             dir_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] tog;
  logic             bank_clr;
  logic             launch;
  logic             at_tgt;

  assign at_tgt = (data_out == tgt_q);

  // carry/borrow chain: bit i toggles when all lower bits are 1 (up) or 0 (down)
  assign tog[0] = 1'b1;
  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_tog
      assign tog[i] = dir_q ? (&data_out[i-1:0]) : ~(|data_out[i-1:0]);
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
      t_ff_bank_sequencer_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .clr   (bank_clr),
        .t     (t_en[i]),
        .q     (data_out[i])
      );
    end
  endgenerate

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state and outputs; stop beats start everywhere
  always_comb begin
    state_nxt = state;
    t_en      = '0;
    busy      = 1'b0;
    done      = 1'b0;
    bank_clr  = 1'b0;
    launch    = 1'b0;
    case (state)
      S_IDLE: begin
        bank_clr = clear;
        if (start && !stop) begin
          launch    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (stop)        state_nxt = S_PAUSE;
        else if (at_tgt) state_nxt = S_DONE;
        else             t_en = tog;
      end
      S_PAUSE: begin
        busy = 1'b1;
        if (stop)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_RUN;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // run parameters captured at launch and held for the whole run
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q <= 1'b1;
      tgt_q <= '0;
    end else if (launch) begin
      dir_q <= up_down;
      tgt_q <= target;
    end
  end

`ifdef TFF_SEQ_STEP_CNT_EN
  // count toggle cycles of the current run, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            step_cnt <= '0;
    else if (launch)                       step_cnt <= '0;
    else if ((|t_en) && !(&step_cnt))      step_cnt <= step_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_t_ff_bank_sequencer.sv
// Self-checking bench for t_ff_bank_sequencer (WIDTH=8).
module tb_t_ff_bank_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0, up_down = 1'b1;
  logic [7:0] target = '0;
  logic [7:0] t_en, data_out;
  logic       busy, done;
`ifdef TFF_SEQ_STEP_CNT_EN
  logic [8:0] step_cnt;
`endif

  t_ff_bank_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up_down  (up_down),
    .target   (target),
    .t_en     (t_en),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
`ifdef TFF_SEQ_STEP_CNT_EN
    ,.step_cnt(step_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [7:0] te; } exp_t;
  typedef struct { logic clr; logic [7:0] from; logic up; logic [7:0] tgt; } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected RUN-cycle samples: value and toggle vector = value ^ next value
  function automatic void push_range(input logic [7:0] from, input logic up, input int n, input bit fin);
    logic [7:0] d, nx;
    d = from;
    for (int i = 0; i < n; i++) begin
      nx = up ? d + 8'd1 : d - 8'd1;
      sb.push_back('{d, d ^ nx});
      d = nx;
    end
    if (fin) sb.push_back('{d, 8'h00});
  endfunction

  task automatic consume_one(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty while DUT running", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_data"}, data_out, e.d);
      chk({nm, "_ten"},  t_en,     e.te);
      chk({nm, "_busy"}, busy,     1'b1);
      chk({nm, "_done"}, done,     1'b0);
    end
  endtask

  task automatic drain(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      consume_one(nm);
      @(negedge clk);
    end
  endtask

  task automatic finish_run(input string nm, input logic [7:0] tgt, input int cnt);
    chk({nm, "_done_hi"}, done, 1'b1);
    chk({nm, "_done_busy"}, busy, 1'b0);
    chk({nm, "_done_data"}, data_out, tgt);
    chk({nm, "_done_ten"}, t_en, 8'h00);
`ifdef TFF_SEQ_STEP_CNT_EN
    chk({nm, "_step_cnt"}, step_cnt, cnt[8:0]);
`endif
    @(negedge clk);
    chk({nm, "_done_lo"}, done, 1'b0);
    chk({nm, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic launch(input logic clr, input logic up, input logic [7:0] tgt);
    clear = clr; start = 1'b1; up_down = up; target = tgt;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    up_down = ~up; target = ~tgt;  // must be ignored: latched at launch
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k;
    k = v.up ? int'(8'(v.tgt - v.from)) : int'(8'(v.from - v.tgt));
    push_range(v.from, v.up, k, 1'b1);
    launch(v.clr, v.up, v.tgt);
    drain(nm, k + 1);
    finish_run(nm, v.tgt, k);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8'h00, 1'b1, 8'd10};   // basic count up
    vecs[1] = '{1'b1, 8'h00, 1'b1, 8'hFE};   // preload FE
    vecs[2] = '{1'b0, 8'hFE, 1'b1, 8'h01};   // wrap up through FF
    vecs[3] = '{1'b1, 8'h00, 1'b1, 8'h03};   // preload 3
    vecs[4] = '{1'b0, 8'h03, 1'b0, 8'hFD};   // wrap down through 0
    vecs[5] = '{1'b0, 8'hFD, 1'b1, 8'hFD};   // target == current: zero steps
    vecs[6] = '{1'b1, 8'h00, 1'b1, 8'h09};   // preload 9
    vecs[7] = '{1'b1, 8'h00, 1'b1, 8'h02};   // clear+start: runs from 0

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ten",  t_en, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
`ifdef TFF_SEQ_STEP_CNT_EN
    chk("rst_step_cnt", step_cnt, 9'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // pause at 7, hold 4 cycles, resume to 20
    push_range(8'd0, 1'b1, 8, 1'b0);
    launch(1'b1, 1'b1, 8'd20);
    for (int i = 0; i < 8; i++) begin
      consume_one("pause_a");
      if (i == 7) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pause_data", data_out, 8'd7);
      chk("pause_busy", busy, 1'b1);
      chk("pause_ten",  t_en, 8'h00);
      chk("pause_done", done, 1'b0);
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_range(8'd7, 1'b1, 13, 1'b1);
    drain("pause_b", 14);
    finish_run("pause", 8'd20, 20);

    // stop twice aborts to IDLE without done
    launch(1'b1, 1'b1, 8'd20);
    repeat (2) @(negedge clk);
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_data", data_out, 8'd2);
      @(negedge clk);
    end

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 1'b0);
    chk("ss_data", data_out, 8'd2);
    @(negedge clk);
    chk("ss_busy2", busy, 1'b0);
    chk("ss_ten", t_en, 8'h00);

    // asynchronous reset in the middle of a run at data_out=5
    launch(1'b1, 1'b1, 8'd20);
    begin
      int budget;
      budget = 30;
      while (data_out != 8'd5 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rst_wait: data_out %0h never reached 5", data_out);
      end
    end
    #2 reset = 1'b0;
    #1;
    chk("arst_data", data_out, 8'h00);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_ten",  t_en, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_idle_busy", busy, 1'b0);
      chk("arst_idle_done", done, 1'b0);
      chk("arst_idle_data", data_out, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
